id_scoreboard: RTL and testbench
================================

Name: id_scoreboard

Overview:
- Parametrised register scoreboard between the decode stage and the issue point of the pipelined core.
- Tracks every in-flight register writer by pipeline stage and load/ALU type.
- Raises a read-after-write stall only when a source operand cannot yet be forwarded; otherwise emits per-operand forward-select codes.
- Replaces the single-cycle, compare-against-EX-only hazard check with depth-generic tracking, write-after-write handling, flush squashing and a stall counter.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-zero and never tracked.
- AW, 5, register address width; must be at least clog2(NREG).
- DEPTH, 3, stages after ID before register-file write (EX=1, MEM=2, WB=3).
- SW, 2, stage field width; must be at least clog2(DEPTH+1).
- ALU_AVAIL, 1, first stage at which an ALU result is forwardable.
- LOAD_AVAIL, 2, first stage at which load data is forwardable.
- CNTW, 32, stall-cycle counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decoded instruction present in ID.
- issue_ready  out  1  instruction may leave ID this cycle.
- rs1_addr  in  AW  source 1 register.
- rs1_used  in  1  instruction reads rs1.
- rs2_addr  in  AW  source 2 register.
- rs2_used  in  1  instruction reads rs2.
- rd_addr  in  AW  destination register.
- rd_write  in  1  instruction writes rd.
- is_load  in  1  instruction is a load.
- flush  in  1  squash the ID instruction and the wrong-path instruction now in EX.
- fwd1_sel  out  SW  rs1 source: 0 = register file, k = result of stage k.
- fwd2_sel  out  SW  rs2 source, same encoding.
- stall_raw  out  1  ID held by a data hazard.
- busy_mask  out  NREG  bit r set when register r has a pending writer.
- stall_cnt  out  CNTW  saturating count of stall_raw cycles.

Behaviour:
- Per-register state: stage[r] (SW bits, 0 = idle) and ld[r] (1 bit).
- Reset: all stage, ld and stall_cnt go to 0 asynchronously while rst_n is low. Outputs during reset: issue_ready=1, stall_raw=0, fwd*_sel=0, busy_mask=0.
- Hazard on source x: x_used, x_addr!=0, stage[x]!=0, and stage[x] < (ld[x] ? LOAD_AVAIL : ALU_AVAIL).
- stall_raw = issue_valid & (hazard rs1 | hazard rs2) & !flush. This is combinational, zero latency.
- issue_ready = !stall_raw & !flush.
- Accepted issue = issue_valid & issue_ready.
- fwd_sel (combinational):
  - 0 when the source is unused, addr=0, or stage=0.
  - Otherwise equals stage[x].
  - Value is don't-care while stall_raw=1.
- Advance, every clock:
  - Each nonzero stage increments.
  - A stage that reaches DEPTH returns to 0 on the next edge. Its value becomes visible in the register file the cycle it leaves DEPTH, so readers use fwd=0 from then on.
- Issue write, on an accepted issue with rd_write & rd!=0: stage[rd] <= 1 and ld[rd] <= is_load.
  - Issue overrides the advance on the same register (WAW: the youngest writer wins).
  - An older in-flight writer to the same rd is forgotten.
- A stalled cycle inserts a bubble: nothing is tracked.
- Flush: every entry with stage==1 clears to 0 that edge, and no issue is accepted. Entries at stage >= 2 advance normally.
- Flush and stall in the same cycle: flush wins and stall_raw=0.
- rd_write with rd=0 is ignored. Register 0 is always idle and its busy_mask bit is always 0.
- stall_cnt increments on each stall_raw cycle and saturates at all-ones.
- Reset mid-operation clears all pending state. After release the first instruction issues without stall.

Decomposition:
- Shared package (core_pkg) holds:
  - fwd_sel encodings FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3.
  - Default DEPTH, ALU_AVAIL, LOAD_AVAIL.
  - Opcode constants shared with the decoder.
- One natural sub-module, sb_entry: a single register's stage/ld state with advance, issue and flush logic. It is instantiated NREG-1 times via generate.
- Hazard/forward muxing stays in the top level.

Test Plan:
- Back-to-back ALU dependence, default parameters:
  - Stimulus: issue addi x5 (rd_write=1, is_load=0), then add x6,x5,x5 the next cycle.
  - Expect: no stall; fwd1_sel=fwd2_sel=1; busy_mask[5]=1 for 3 cycles, then 0.
- Load-use:
  - Stimulus: lw x7, then add x8,x7,x0 the next cycle.
  - Expect: stall_raw=1 for exactly 1 cycle; then issue with fwd1_sel=2; stall_cnt=1.
- WAW:
  - Stimulus: lw x9, an unrelated instruction, then addi x9 (x9 at stage 2), then a reader of x9.
  - Expect: no stall; fwd_sel=1; the old load entry is discarded.
- Flush:
  - Stimulus: issue lw x3; the next cycle assert flush with a reader of x3 valid.
  - Expect: issue_ready=0 and stall_raw=0; the following cycle busy_mask[3]=0 and a reader of x3 gets fwd_sel=0 with no stall.
- x0 and unused operands:
  - Stimulus: lw x0 followed by a read of x0; separately, rs2_used=0 with rs2_addr equal to a pending load rd.
  - Expect: no stall, fwd_sel=0 in both cases.
- Async reset with entries pending at stages 1-3, plus a wide configuration:
  - Stimulus: drop rst_n between edges with entries pending; separately, run DEPTH=4, SW=3, LOAD_AVAIL=3.
  - Expect: reset zeroes busy_mask and stall_cnt immediately. In the wide configuration, a load-use stalls 2 cycles and then fwd_sel=3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: forward-select encodings, default pipeline
// geometry and the opcode constants the decoder and scoreboard agree on.
package core_pkg;

  // Forward-select codes name the stage whose result feeds an operand.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  localparam int DEF_DEPTH      = 3;
  localparam int DEF_ALU_AVAIL  = 1;
  localparam int DEF_LOAD_AVAIL = 2;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  // First stage at which a writer of the given kind can be forwarded.
  function automatic int avail_stage(input logic is_load,
                                     input int   alu_avail,
                                     input int   load_avail);
    return is_load ? load_avail : alu_avail;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One architectural register's scoreboard entry: pipeline stage of its
// youngest in-flight writer (0 = idle) and whether that writer is a load.
module sb_entry
  import core_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_hit,
  input  logic          issue_load,
  input  logic          flush,
  output logic [SW-1:0] stage,
  output logic          ld
);

  logic [SW-1:0] stage_d;
  logic          ld_d;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    stage_d = stage;
    ld_d    = ld;
    if (issue_hit) begin
      // A new writer replaces any older one still in flight (youngest wins).
      stage_d = SW'(1);
      ld_d    = issue_load;
    end else if (stage == '0) begin
      stage_d = '0;
    end else if ((flush && stage == SW'(1)) || stage == SW'(DEPTH)) begin
      // Wrong-path writer squashed, or the value has reached the register file.
      stage_d = '0;
      ld_d    = 1'b0;
    end else begin
      stage_d = stage + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      stage <= '0;
      ld    <= 1'b0;
    end else begin
      stage <= stage_d;
      ld    <= ld_d;
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// Register scoreboard between decode and issue: tracks in-flight writers,
// selects forwarding sources and stalls only on unforwardable RAW hazards.
module id_scoreboard
  import core_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SW         = 2,
  parameter int ALU_AVAIL  = DEF_ALU_AVAIL,
  parameter int LOAD_AVAIL = DEF_LOAD_AVAIL,
  parameter int CNTW       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic            rs1_used,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs2_used,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_write,
  input  logic            is_load,
  input  logic            flush,
  output logic [SW-1:0]   fwd1_sel,
  output logic [SW-1:0]   fwd2_sel,
  output logic            stall_raw,
  output logic [NREG-1:0] busy_mask,
  output logic [CNTW-1:0] stall_cnt
);

  // Register 0 is hard-zero, so entries exist only for 1..NREG-1.
  logic [SW-1:0] stage_q [1:NREG-1];
  logic          ld_q    [1:NREG-1];

  logic          accept;
  logic [SW-1:0] s1, s2;
  logic          l1, l2;
  logic [SW-1:0] need1, need2;
  logic          rd1, rd2;
  logic          haz1, haz2;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic hit;
    assign hit = accept & rd_write & (rd_addr == AW'(r));

    sb_entry #(
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_hit  (hit),
      .issue_load (is_load),
      .flush      (flush),
      .stage      (stage_q[r]),
      .ld         (ld_q[r])
    );
  end

  // Source lookup: address 0 and out-of-range addresses read as idle.
  always_comb begin
    s1 = '0;
    l1 = 1'b0;
    s2 = '0;
    l2 = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (rs1_addr == AW'(r)) begin
        s1 = stage_q[r];
        l1 = ld_q[r];
      end
      if (rs2_addr == AW'(r)) begin
        s2 = stage_q[r];
        l2 = ld_q[r];
      end
    end
  end

  always_comb begin
    need1 = SW'(avail_stage(l1, ALU_AVAIL, LOAD_AVAIL));
    need2 = SW'(avail_stage(l2, ALU_AVAIL, LOAD_AVAIL));
    rd1   = rs1_used & (rs1_addr != '0);
    rd2   = rs2_used & (rs2_addr != '0);
    // A pending writer only hurts while it is younger than its forward point.
    haz1  = rd1 & (s1 != '0) & (s1 < need1);
    haz2  = rd2 & (s2 != '0) & (s2 < need2);
  end

  // Flush dominates: the ID instruction is squashed, so it cannot stall.
  assign stall_raw   = issue_valid & (haz1 | haz2) & ~flush;
  assign issue_ready = ~stall_raw & ~flush;
  assign accept      = issue_valid & issue_ready;

  assign fwd1_sel = rd1 ? s1 : SW'(FWD_RF);
  assign fwd2_sel = rd2 ? s2 : SW'(FWD_RF);

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_mask[r] = (stage_q[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_raw && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: a default and a wide (DEPTH=4) instance share
// stimulus; each is compared against a writer-age model of the scoreboard.
module tb_id_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_used, rs2_used, rd_write, is_load, flush;

  logic        issue_ready_a, stall_raw_a;
  logic [1:0]  fwd1_a, fwd2_a;
  logic [31:0] busy_a, cnt_a;

  logic        issue_ready_b, stall_raw_b;
  logic [2:0]  fwd1_b, fwd2_b;
  logic [31:0] busy_b;
  logic [3:0]  cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  id_scoreboard u_dut_a (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready_a),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .rd_addr(rd_addr), .rd_write(rd_write), .is_load(is_load), .flush(flush),
    .fwd1_sel(fwd1_a), .fwd2_sel(fwd2_a), .stall_raw(stall_raw_a),
    .busy_mask(busy_a), .stall_cnt(cnt_a)
  );

  id_scoreboard #(.DEPTH(4), .SW(3), .LOAD_AVAIL(3), .CNTW(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready_b),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .rd_addr(rd_addr), .rd_write(rd_write), .is_load(is_load), .flush(flush),
    .fwd1_sel(fwd1_b), .fwd2_sel(fwd2_b), .stall_raw(stall_raw_b),
    .busy_mask(busy_b), .stall_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each register remembers the cycle its youngest writer issued;
  // its stage is simply the writer's age, idle once older than DEPTH.
  int     depth_c [2] = '{3, 4};
  int     la_c    [2] = '{2, 3};
  int     aa_c    [2] = '{1, 1};
  longint cmax_c  [2] = '{64'hFFFF_FFFF, 15};
  int     t_iss   [2][32];
  bit     mld     [2][32];
  longint m_cnt   [2];
  bit     e_stall [2];
  bit     e_acc   [2];
  int     now = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int mstage(input int c, input int r);
    int d;
    if (r == 0 || t_iss[c][r] < 0) return 0;
    d = now - t_iss[c][r] + 1;
    return (d >= 1 && d <= depth_c[c]) ? d : 0;
  endfunction

  function automatic bit mhaz(input int c, input bit used, input int a);
    int s;
    s = mstage(c, a);
    return used && a != 0 && s != 0 && s < (mld[c][a] ? la_c[c] : aa_c[c]);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0;
      for (int r = 0; r < 32; r++) begin
        t_iss[c][r] = -1;
        mld[c][r]   = 1'b0;
      end
    end
  endtask

  // Apply one ID-stage instruction after the falling edge and check both DUTs.
  task automatic drive(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                       input int rd, input bit w, input bit ld, input bit fl);
    @(negedge clk);
    issue_valid = v;
    rs1_addr = 5'(a1);  rs1_used = u1;
    rs2_addr = 5'(a2);  rs2_used = u2;
    rd_addr  = 5'(rd);  rd_write = w;
    is_load  = ld;      flush    = fl;
    #1;
    for (int c = 0; c < 2; c++) begin
      bit          es;
      logic [31:0] eb;
      int          ef1, ef2;
      es = v && (mhaz(c, u1, a1) || mhaz(c, u2, a2)) && !fl;
      eb = '0;
      for (int r = 1; r < 32; r++) eb[r] = (mstage(c, r) != 0);
      e_stall[c] = es;
      e_acc[c]   = v && !es && !fl;
      check($sformatf("stall_raw/%0d", c), c ? stall_raw_b : stall_raw_a, es);
      check($sformatf("issue_ready/%0d", c), c ? issue_ready_b : issue_ready_a, !es && !fl);
      check($sformatf("busy_mask/%0d", c), c ? busy_b : busy_a, eb);
      check($sformatf("stall_cnt/%0d", c), c ? {28'b0, cnt_b} : cnt_a, m_cnt[c]);
      if (!es) begin
        ef1 = (u1 && a1 != 0) ? mstage(c, a1) : 0;
        ef2 = (u2 && a2 != 0) ? mstage(c, a2) : 0;
        check($sformatf("fwd1_sel/%0d", c), c ? fwd1_b : {1'b0, fwd1_a}, ef1);
        check($sformatf("fwd2_sel/%0d", c), c ? fwd2_b : {1'b0, fwd2_a}, ef2);
      end
    end
  endtask

  // Clock edge: age the model, squash wrong-path writers, record new issue.
  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (e_stall[c] && m_cnt[c] < cmax_c[c]) m_cnt[c]++;
      if (flush)
        for (int r = 1; r < 32; r++)
          if (mstage(c, r) == 1) t_iss[c][r] = -1;
      if (e_acc[c] && rd_write && rd_addr != 0) begin
        t_iss[c][rd_addr] = now + 1;
        mld[c][rd_addr]   = is_load;
      end
    end
    now++;
  endtask

  task automatic step(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                      input int rd, input bit w, input bit ld, input bit fl);
    drive(v, a1, u1, a2, u2, rd, w, ld, fl);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between clock edges; state must clear without waiting for clk.
  task automatic reset_mid();
    @(negedge clk);
    issue_valid = 1'b0;
    flush       = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst busy_mask/0", busy_a, 0);
    check("rst busy_mask/1", busy_b, 0);
    check("rst stall_cnt/0", cnt_a, 0);
    check("rst stall_cnt/1", {28'b0, cnt_b}, 0);
    check("rst issue_ready/0", issue_ready_a, 1);
    check("rst stall_raw/1", stall_raw_b, 0);
    model_clear();
    @(posedge clk);
    now++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    issue_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    rs1_used = 0; rs2_used = 0; rd_write = 0; is_load = 0; flush = 0;
    model_clear();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("init busy_mask", busy_a, 0);
    check("init stall_cnt", cnt_a, 0);
    check("init issue_ready", issue_ready_a, 1);
    check("init fwd1_sel", fwd1_a, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ALU dependence: forwarded from EX, no stall.
    step(1, 0, 1, 0, 0, 5, 1, 0, 0);
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
    check("alu stall", stall_raw_a, 0);
    check("alu fwd1", fwd1_a, 1);
    check("alu fwd2", fwd2_a, 1);
    check("alu busy5 c1", busy_a[5], 1);
    tick();
    for (int i = 2; i <= 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("alu busy5 c%0d", i), busy_a[5], 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("alu busy5 retired", busy_a[5], 0);
    tick();
    drain();

    // Load-use: one stall by default, two in the wide configuration.
    step(1, 0, 1, 0, 0, 7, 1, 1, 0);
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
    check("ldu stall c1/0", stall_raw_a, 1);
    check("ldu stall c1/1", stall_raw_b, 1);
    tick();
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
    check("ldu stall c2/0", stall_raw_a, 0);
    check("ldu fwd1/0", fwd1_a, 2);
    check("ldu stall c2/1", stall_raw_b, 1);
    tick();
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
    check("ldu stall c3/1", stall_raw_b, 0);
    check("ldu fwd1/1", fwd1_b, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ldu stall_cnt/0", cnt_a, 1);
    check("ldu stall_cnt/1", cnt_b, 2);
    tick();
    drain();

    // WAW: a younger ALU writer replaces the pending load of x9.
    step(1, 0, 1, 0, 0, 9, 1, 1, 0);
    step(1, 0, 1, 0, 0, 10, 1, 0, 0);
    step(1, 0, 1, 0, 0, 9, 1, 0, 0);
    drive(1, 9, 1, 9, 1, 11, 1, 0, 0);
    check("waw stall/0", stall_raw_a, 0);
    check("waw fwd1/0", fwd1_a, 1);
    check("waw stall/1", stall_raw_b, 0);
    check("waw fwd2/1", fwd2_b, 1);
    tick();
    drain();

    // Flush squashes the EX-stage load and the ID reader.
    step(1, 0, 1, 0, 0, 3, 1, 1, 0);
    drive(1, 3, 1, 0, 0, 12, 1, 0, 1);
    check("flush ready", issue_ready_a, 0);
    check("flush stall", stall_raw_a, 0);
    tick();
    drive(1, 3, 1, 0, 0, 12, 1, 0, 0);
    check("flush busy3", busy_a[3], 0);
    check("flush fwd1", fwd1_a, 0);
    check("flush stall after", stall_raw_a, 0);
    tick();
    drain();

    // x0 is never tracked; unused operands never hazard.
    drive(1, 0, 1, 0, 0, 0, 1, 1, 0);
    check("x0 busy", busy_a, 0);
    tick();
    drive(1, 0, 1, 0, 1, 13, 1, 0, 0);
    check("x0 stall", stall_raw_a, 0);
    check("x0 fwd1", fwd1_a, 0);
    tick();
    step(1, 0, 1, 0, 0, 11, 1, 1, 0);
    drive(1, 12, 1, 11, 0, 14, 1, 0, 0);
    check("unused stall", stall_raw_a, 0);
    check("unused fwd2", fwd2_a, 0);
    tick();
    drain();

    // Reset with writers pending at stages 1..3, then an immediate reader.
    step(1, 0, 1, 0, 0, 1, 1, 1, 0);
    step(1, 0, 1, 0, 0, 2, 1, 1, 0);
    step(1, 0, 1, 0, 0, 4, 1, 0, 0);
    reset_mid();
    drive(1, 1, 1, 2, 1, 15, 1, 0, 0);
    check("post-rst stall/0", stall_raw_a, 0);
    check("post-rst stall/1", stall_raw_b, 0);
    tick();

    // Randomised traffic on a small register window to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid();
      end else begin
        step($urandom_range(0, 99) < 85,
             $urandom_range(0, 7), $urandom_range(0, 99) < 85,
             $urandom_range(0, 7), $urandom_range(0, 99) < 70,
             $urandom_range(0, 7), $urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 8);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
